// File: rtl/dump_ctrl.sv
// dump_ctrl: readback sequencer for the capture RAM queues.
// Reads all ENTRIES samples of one channel, oldest first, starting at the
// capture write pointer and wrapping at ENTRIES-1. Each byte goes to the
// UART with a trmt/tx_done handshake.
module dump_ctrl #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dump_go,
  input  logic [2:0]      dump_chan,
  input  logic [LOG2-1:0] waddr_cap,
  input  logic [7:0]      ch0_rdata,
  input  logic [7:0]      ch1_rdata,
  input  logic [7:0]      ch2_rdata,
  input  logic [7:0]      ch3_rdata,
  input  logic [7:0]      ch4_rdata,
  input  logic            tx_done,
  output logic [LOG2-1:0] raddr,
  output logic            ren,
  output logic [7:0]      tx_data,
  output logic            trmt,
  output logic            dump_busy,
  output logic            dump_cmplt,
  output logic            dump_err
);

  typedef enum logic [1:0] {IDLE, RD, LD, TX} state_t;

  localparam logic [15:0]     LAST_CNT  = 16'(ENTRIES - 1);
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

  state_t          state_reg, state_next;
  logic [2:0]      chan_reg, chan_next;
  logic [LOG2-1:0] raddr_reg, raddr_next;
  logic [15:0]     byte_cnt_reg, byte_cnt_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            trmt_reg, trmt_next;
  logic            cmplt_reg, cmplt_next;
  logic            err_reg, err_next;

  logic [7:0] rdata_sel;
  logic       go_ok;
  logic       go_bad;
  logic       last_byte;

  assign go_ok     = dump_go && (dump_chan <= 3'd4);
  assign go_bad    = dump_go && (dump_chan > 3'd4);
  assign last_byte = (byte_cnt_reg == LAST_CNT);

  // Select the read data of the channel latched at accept time
  always_comb begin
    rdata_sel = 8'h00;
    case (chan_reg)
      3'd0:    rdata_sel = ch0_rdata;
      3'd1:    rdata_sel = ch1_rdata;
      3'd2:    rdata_sel = ch2_rdata;
      3'd3:    rdata_sel = ch3_rdata;
      3'd4:    rdata_sel = ch4_rdata;
      default: rdata_sel = 8'h00;
    endcase
  end

  // State register; reset aborts any dump without a completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: RD and LD are fixed single cycles, TX waits for tx_done
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (go_ok) state_next = RD;
      RD:      state_next = LD;
      LD:      state_next = TX;
      TX:      if (tx_done) state_next = last_byte ? IDLE : RD;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath next values; strobes default low so they last one cycle
  always_comb begin
    chan_next     = chan_reg;
    raddr_next    = raddr_reg;
    byte_cnt_next = byte_cnt_reg;
    tx_data_next  = tx_data_reg;
    trmt_next     = 1'b0;
    cmplt_next    = 1'b0;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go_ok) begin
          chan_next     = dump_chan;
          raddr_next    = waddr_cap;
          byte_cnt_next = 16'd0;
        end
        if (go_bad) err_next = 1'b1;
      end
      LD: begin
        tx_data_next = rdata_sel;
        trmt_next    = 1'b1;
      end
      TX: begin
        if (tx_done) begin
          if (last_byte) begin
            cmplt_next = 1'b1;
          end else begin
            byte_cnt_next = byte_cnt_reg + 16'd1;
            raddr_next    = (raddr_reg == LAST_ADDR) ? '0 : raddr_reg + LOG2'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_reg     <= 3'd0;
      raddr_reg    <= '0;
      byte_cnt_reg <= 16'd0;
      tx_data_reg  <= 8'h00;
      trmt_reg     <= 1'b0;
      cmplt_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      chan_reg     <= chan_next;
      raddr_reg    <= raddr_next;
      byte_cnt_reg <= byte_cnt_next;
      tx_data_reg  <= tx_data_next;
      trmt_reg     <= trmt_next;
      cmplt_reg    <= cmplt_next;
      err_reg      <= err_next;
    end
  end

  assign raddr      = raddr_reg;
  assign ren        = (state_reg == RD);
  assign tx_data    = tx_data_reg;
  assign trmt       = trmt_reg;
  assign dump_busy  = (state_reg != IDLE);
  assign dump_cmplt = cmplt_reg;
  assign dump_err   = err_reg;

endmodule

// File: tb/tb_dump_ctrl.sv
// tb_dump_ctrl: self-checking bench for dump_ctrl with a RAM/UART model.
module tb_dump_ctrl;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic            clk;
  logic            rst_n;
  logic            dump_go;
  logic [2:0]      dump_chan;
  logic [LOG2-1:0] waddr_cap;
  logic [7:0]      ch0_rdata, ch1_rdata, ch2_rdata, ch3_rdata, ch4_rdata;
  logic            tx_done;
  logic [LOG2-1:0] raddr;
  logic            ren;
  logic [7:0]      tx_data;
  logic            trmt;
  logic            dump_busy;
  logic            dump_cmplt;
  logic            dump_err;

  dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst_n(rst_n), .dump_go(dump_go), .dump_chan(dump_chan),
    .waddr_cap(waddr_cap), .ch0_rdata(ch0_rdata), .ch1_rdata(ch1_rdata),
    .ch2_rdata(ch2_rdata), .ch3_rdata(ch3_rdata), .ch4_rdata(ch4_rdata),
    .tx_done(tx_done), .raddr(raddr), .ren(ren), .tx_data(tx_data),
    .trmt(trmt), .dump_busy(dump_busy), .dump_cmplt(dump_cmplt),
    .dump_err(dump_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endfunction

  // Channel contents: ch2 holds address[7:0], others distinct per channel
  function automatic logic [7:0] mem_val(input int ch, input int a);
    int v;
    if (ch == 2) v = a;
    else v = a * 3 + ch * 50;
    return 8'(v & 255);
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // RAM queues with one-cycle registered read
  always @(posedge clk) begin
    if (ren) begin
      ch0_rdata <= mem_val(0, int'(raddr));
      ch1_rdata <= mem_val(1, int'(raddr));
      ch2_rdata <= mem_val(2, int'(raddr));
      ch3_rdata <= mem_val(3, int'(raddr));
      ch4_rdata <= mem_val(4, int'(raddr));
    end
  end

  // UART responder: tx_done dly_mode cycles after trmt (-1 = random 0..20)
  int dly_mode = 5;
  bit stray_en = 0;
  int cd;
  initial begin
    cd = -1;
    tx_done = 0;
    forever begin
      @(posedge clk); #1;
      tx_done = 0;
      if (!rst_n) cd = -1;
      else begin
        if (cd > 0) cd--;
        if (trmt) cd = (dly_mode < 0) ? int'($urandom_range(0, 20)) : dly_mode;
        if (cd == 0) begin
          tx_done = 1;
          cd = -1;
        end else if (stray_en && cd < 0 && $urandom_range(0, 2) == 0) begin
          tx_done = 1;
        end
      end
    end
  end

  // Behavioural model: expected address/byte streams per accepted dump
  bit          m_busy = 0;
  bit          pend = 0;
  bit          exp_cmplt = 0;
  bit          exp_err = 0;
  int          acked = 0;
  int          n_trmt = 0;
  int          n_cmplt_seen = 0;
  int          exp_addr[$];
  logic [7:0]  exp_byte[$];
  logic [7:0]  got_bytes[$];
  int          got_addr[$];
  int          got_tcyc[$];
  int          seen[512];

  // Compare process: checks DUT against the model on every cycle
  always @(negedge clk) begin
    bit nb;
    int a;
    int bad;
    if (!rst_n) begin
      check("rst_raddr", 32'(raddr), 0);
      check("rst_ren", 32'(ren), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_trmt", 32'(trmt), 0);
      check("rst_busy", 32'(dump_busy), 0);
      check("rst_cmplt", 32'(dump_cmplt), 0);
      check("rst_err", 32'(dump_err), 0);
      m_busy = 0; pend = 0; acked = 0; exp_cmplt = 0; exp_err = 0;
      exp_addr.delete();
      exp_byte.delete();
    end else begin
      check("busy", 32'(dump_busy), 32'(m_busy));
      check("cmplt", 32'(dump_cmplt), 32'(exp_cmplt));
      check("err", 32'(dump_err), 32'(exp_err));
      if (dump_cmplt) n_cmplt_seen++;
      if (!m_busy) begin
        check("idle_ren", 32'(ren), 0);
        check("idle_trmt", 32'(trmt), 0);
      end
      if (ren) begin
        check("ren_in_budget", 32'(exp_addr.size() != 0), 1);
        if (exp_addr.size() != 0) begin
          a = exp_addr.pop_front();
          check("raddr", 32'(raddr), 32'(a));
          got_addr.push_back(int'(raddr));
          seen[raddr]++;
        end
      end
      if (trmt) begin
        check("trmt_single", 32'(pend), 0);
        check("trmt_in_budget", 32'(exp_byte.size() != 0), 1);
        if (exp_byte.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_byte.pop_front()));
        got_bytes.push_back(tx_data);
        got_tcyc.push_back(cyc);
        n_trmt++;
        pend = 1;
      end
      nb = m_busy;
      exp_cmplt = 0;
      exp_err = 0;
      if (tx_done && pend) begin
        pend = 0;
        acked++;
        if (acked == ENTRIES) begin
          exp_cmplt = 1;
          nb = 0;
          check("bytes_per_dump", 32'(n_trmt), ENTRIES);
          bad = 0;
          for (int i = 0; i < 512; i++) if (seen[i] != (i < ENTRIES ? 1 : 0)) bad++;
          check("addr_once_each", 32'(bad), 0);
        end
      end
      if (!m_busy && dump_go) begin
        if (dump_chan <= 3'd4) begin
          nb = 1;
          exp_addr.delete();
          exp_byte.delete();
          for (int i = 0; i < ENTRIES; i++) begin
            a = (int'(waddr_cap) + i) % ENTRIES;
            exp_addr.push_back(a);
            exp_byte.push_back(mem_val(int'(dump_chan), a));
          end
          got_bytes.delete();
          got_addr.delete();
          got_tcyc.delete();
          for (int i = 0; i < 512; i++) seen[i] = 0;
          n_trmt = 0; acked = 0; pend = 0;
        end else begin
          exp_err = 1;
        end
      end
      m_busy = nb;
    end
  end

  // Issue an accepted dump and pin the first-byte latency
  task automatic start_dump(input int ch, input int wc);
    dump_go = 1; dump_chan = 3'(ch); waddr_cap = 9'(wc);
    @(posedge clk); #1;
    dump_go = 0; waddr_cap = 9'((wc + 37) % ENTRIES); dump_chan = 3'((ch + 1) % 5);
    check("lat_ren", 32'(ren), 1);
    check("lat_raddr", 32'(raddr), 32'(wc));
    @(posedge clk); #1;
    check("lat_trmt_early", 32'(trmt), 0);
    @(posedge clk); #1;
    check("lat_trmt", 32'(trmt), 1);
  endtask

  task automatic wait_cmplt(input int bound);
    int n = 0;
    while (dump_cmplt !== 1'b1 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmplt_seen", 32'(dump_cmplt), 1);
  endtask

  initial begin
    int n0;
    rst_n = 0; dump_go = 0; dump_chan = 0; waddr_cap = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    // Basic dump on ch2 from address 0
    dly_mode = 5;
    start_dump(2, 0);
    wait_cmplt(10000);
    $display("dump ch2 wc=0 bytes=%0d", got_bytes.size());
    check("a_count", 32'(got_bytes.size()), 384);
    check("a_byte0", 32'(got_bytes[0]), 32'h00);
    check("a_byte255", 32'(got_bytes[255]), 32'hFF);
    check("a_byte256", 32'(got_bytes[256]), 32'h00);
    check("a_byte383", 32'(got_bytes[383]), 32'h7F);
    repeat (2) @(posedge clk); #1;

    // Wrap from address 100 on ch1
    n0 = n_cmplt_seen;
    start_dump(1, 100);
    wait_cmplt(10000);
    @(posedge clk); #1;
    $display("dump ch1 wc=100 addrs=%0d", got_addr.size());
    check("b_cmplt_once", 32'(n_cmplt_seen), 32'(n0 + 1));
    check("b_addr0", 32'(got_addr[0]), 100);
    check("b_addr283", 32'(got_addr[283]), 383);
    check("b_addr284", 32'(got_addr[284]), 0);
    check("b_addr383", 32'(got_addr[383]), 99);
    @(posedge clk); #1;

    // Invalid channels
    dump_go = 1; dump_chan = 3'd5;
    @(posedge clk); #1;
    check("c_err5", 32'(dump_err), 1);
    check("c_busy", 32'(dump_busy), 0);
    check("c_ren", 32'(ren), 0);
    dump_chan = 3'd7;
    @(posedge clk); #1;
    dump_go = 0;
    check("c_err7", 32'(dump_err), 1);
    @(posedge clk); #1;
    check("c_err_clear", 32'(dump_err), 0);
    $display("invalid channel requests done");

    // Busy lockout on ch4, then back-to-back accept on ch0
    dly_mode = 2;
    start_dump(4, 300);
    repeat (200) @(posedge clk); #1;
    dump_go = 1; dump_chan = 3'd0; waddr_cap = 9'd7;
    @(posedge clk); #1;
    dump_chan = 3'd6;
    @(posedge clk); #1;
    dump_go = 0;
    wait_cmplt(10000);
    $display("dump ch4 wc=300 bytes=%0d", got_bytes.size());
    check("d_count", 32'(got_bytes.size()), 384);
    check("d_byte0", 32'(got_bytes[0]), 76);
    check("d_byte383", 32'(got_bytes[383]), 73);
    dump_go = 1; dump_chan = 3'd0; waddr_cap = 9'd5;
    dly_mode = -1; stray_en = 1;
    @(posedge clk); #1;
    dump_go = 0;
    check("d_reaccept_busy", 32'(dump_busy), 1);
    check("d_reaccept_raddr", 32'(raddr), 5);

    // Handshake stress with random delays and stray tx_done
    wait_cmplt(15000);
    $display("dump ch0 wc=5 stress bytes=%0d", got_bytes.size());
    stray_en = 0;
    repeat (2) @(posedge clk); #1;

    // Immediate tx_done: 3-cycle byte period
    dly_mode = 0;
    start_dump(3, 383);
    wait_cmplt(10000);
    $display("dump ch3 wc=383 bytes=%0d", got_bytes.size());
    check("e_byte0", 32'(got_bytes[0]), 19);
    check("e_byte1", 32'(got_bytes[1]), 150);
    check("e_space01", 32'(got_tcyc[1] - got_tcyc[0]), 3);
    check("e_space_mid", 32'(got_tcyc[200] - got_tcyc[199]), 3);
    repeat (2) @(posedge clk); #1;

    // Reset mid-dump
    dly_mode = 1;
    start_dump(1, 200);
    n0 = 0;
    while (got_bytes.size() < 51 && n0 < 2000) begin
      @(posedge clk); #1;
      n0++;
    end
    check("f_reached_byte50", 32'(got_bytes.size() >= 51), 1);
    n0 = n_cmplt_seen;
    rst_n = 0;
    #1;
    check("f_async_busy", 32'(dump_busy), 0);
    check("f_async_trmt", 32'(trmt), 0);
    check("f_async_tx_data", 32'(tx_data), 0);
    check("f_async_raddr", 32'(raddr), 0);
    check("f_async_ren", 32'(ren), 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    check("f_no_cmplt", 32'(n_cmplt_seen), 32'(n0));
    $display("reset mid-dump after %0d bytes", 51);
    start_dump(2, 17);
    wait_cmplt(10000);
    @(posedge clk); #1;
    $display("dump ch2 wc=17 after reset addr0=%0d", got_addr[0]);
    check("f_addr0", 32'(got_addr[0]), 17);
    check("f_byte0", 32'(got_bytes[0]), 17);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dump_ctrl.md
# dump_ctrl

Readback sequencer for the capture RAM queues. After a capture completes, it reads all `ENTRIES` samples of one selected channel in chronological order, oldest first, starting at the capture write pointer and wrapping. It hands each byte to the UART transmitter with a `trmt`/`tx_done` handshake. It sits between the command decoder, the five channel RAM queues and the UART TX.

## Interface
- `ENTRIES`, 384, number of samples per channel queue
- `LOG2`, 9, address width; `2^LOG2` ≥ `ENTRIES`

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `dump_go`  in  1  one-cycle dump request from command decoder
- `dump_chan`  in  3  channel select, 0..4 valid (CH1..CH5)
- `waddr_cap`  in  LOG2  capture unit write pointer (oldest sample location)
- `ch0_rdata`..`ch4_rdata`  in  8 each  RAM queue read data, 1-cycle synchronous read latency
- `tx_done`  in  1  UART byte-complete pulse
- `raddr`  out  LOG2  RAM read address, shared by all queues
- `ren`  out  1  RAM read enable
- `tx_data`  out  8  byte to transmit, registered
- `trmt`  out  1  one-cycle transmit strobe, registered
- `dump_busy`  out  1  high whenever state ≠ IDLE
- `dump_cmplt`  out  1  one-cycle pulse after final byte acknowledged
- `dump_err`  out  1  one-cycle pulse on request with invalid channel

## Operation
State machine: `IDLE`, `RD`, `LD`, `TX`.

**IDLE**
- If `dump_go` and `dump_chan` ≤ 4: latch the channel, set `raddr` to `waddr_cap`, clear `byte_cnt`, go to `RD`.
- If `dump_go` and `dump_chan` ≥ 5: pulse `dump_err` next cycle and stay in `IDLE`.

**RD**
- `ren` = 1 and `raddr` is held.
- Go to `LD` unconditionally.

**LD**
- The latched channel's `rdata` is valid.
- Register it into `tx_data` and set `trmt` for one cycle.
- Go to `TX`.

**TX**
- Wait for `tx_done`.
- On `tx_done` with `byte_cnt` == `ENTRIES`-1: go to `IDLE` and pulse `dump_cmplt`.
- On `tx_done` otherwise: increment `byte_cnt`, advance `raddr`, go to `RD`.
- `raddr` advance wraps: if `raddr` == `ENTRIES`-1 it becomes 0, else +1.

Rules and boundary conditions:
- `byte_cnt` is 16 bits, unsigned, compared against `ENTRIES`-1.
- `dump_go` outside `IDLE` is ignored. No queueing and no `dump_err`.
- `tx_done` is sampled only in `TX`. A stray `tx_done` in any other state is ignored.
- `waddr_cap` is sampled only on accepted `dump_go`. Later changes do not affect an in-progress dump.
- `dump_chan` is latched at accept. Later changes are ignored.
- Exactly `ENTRIES` bytes are sent per dump. Every address 0..`ENTRIES`-1 is read exactly once.
- Reset mid-dump aborts immediately to `IDLE`. No `dump_cmplt` is issued.

Reset values (all outputs 0):
- state `IDLE`, `raddr` 0, `ren` 0, `tx_data` 0, `trmt` 0, `dump_cmplt` 0, `dump_err` 0, `byte_cnt` 0.

## Timing
- `dump_go` accepted in cycle 0:
  - `raddr` = `waddr_cap` and `ren` = 1 in cycle 1.
  - `rdata` valid in cycle 2.
  - `trmt` = 1 with valid `tx_data` in cycle 3.
- `tx_done` in cycle k, not the last byte: next `raddr` in k+1, next `trmt` in k+3.
- `tx_done` in cycle k, last byte: `dump_cmplt` = 1 and `dump_busy` = 0 in cycle k+1. A new `dump_go` is accepted in cycle k+1.
- `trmt` is high for exactly one cycle per byte.
- `tx_data` is stable from the `trmt` cycle until the next `LD`.
- `dump_err` is high in the cycle after the rejected `dump_go`.
- Minimum per-byte period is 3 cycles plus UART time (`RD`→`LD`→`TX`, with `tx_done` able to arrive in the first `TX` cycle).

## Test plan
- **Basic dump, ch2:** `waddr_cap`=0, `ch2_rdata` = address[7:0], `tx_done` returned 5 cycles after each `trmt`.
  - Expect 384 `trmt` pulses with `tx_data` 0,1,…,255,0,…,127.
  - Expect `dump_cmplt` 1 cycle after the 384th `tx_done`.
- **Wrap:** `waddr_cap`=100.
  - `raddr` sequence is 100..383, then 0..99.
  - No address is repeated or skipped.
  - `dump_cmplt` is asserted once.
- **Invalid channel:** `dump_chan`=5 with `dump_go`.
  - `dump_err` pulses in the next cycle.
  - `dump_busy`, `trmt` and `ren` stay 0.
- **Busy lockout:** a second `dump_go` with `dump_chan`=0 arrives mid-dump of ch4.
  - Output stays ch4 data and the byte count is still 384.
  - After `dump_cmplt`, a new `dump_go` on ch0 is accepted the next cycle.
- **Handshake stress:** `tx_done` delay randomized 0..20 cycles, plus stray `tx_done` pulses in `RD`/`LD`.
  - Exactly one byte is sent per `TX` state and the sequence is correct.
  - Immediate `tx_done` yields a 3-cycle `trmt` spacing.
- **Reset mid-dump:** assert `rst_n`=0 after byte 50.
  - All outputs are 0 asynchronously and there is no `dump_cmplt`.
  - After release, a new dump starts from the then-current `waddr_cap`.
